// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and default constants for the serial
//                transmitter: the transmit FSM state encoding and the
//                default payload width / bit-period divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Transmit FSM states. IDLE must stay the all-zero encoding so that a
    // cleared state register is a safe idle line.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_CLK_DIV = 868;

endpackage
`default_nettype wire

// File: rtl/bit_order.sv
`default_nettype none
// ============================================================================
//  Module      : bit_order
//  Description : Purely combinational optional bit reversal of a word.
//                out = reverse ? {data[0], data[1], ..., data[DATA_W-1]}
//                              : data
//  Ports       : data    [DATA_W] in  - word to reorder
//                reverse [1]      in  - 1 = mirror the bit order
//                out     [DATA_W] out - reordered word
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_order #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              reverse,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] mirrored;

    for (genvar i = 0; i < DATA_W; i++) begin : g_rev
        assign mirrored[i] = data[DATA_W-1-i];
    end

    assign out = reverse ? mirrored : data;

endmodule
`default_nettype wire

// File: rtl/serial_tx_ordered.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_ordered
//  Description : Serial transmitter with selectable bit order. A one-cycle
//                trigger in IDLE latches data_in (mirrored when big_endian=1)
//                and sends it LSB-first from the shift register, each bit
//                held CLK_DIV cycles, optionally framed by a start bit (0)
//                and a stop bit (1).
//  Parameters  : DATA_W  - payload bits per frame (2..32)
//                CLK_DIV - clk_in cycles per serial bit (2..65535)
//                FRAMED  - 1 = start + payload + stop, 0 = payload only
//  Ports       : clk_in     in   - system clock, rising edge
//                rst_in     in   - asynchronous active-high reset
//                trigger    in   - one-cycle send request (ignored if busy)
//                data_in    in   - payload, sampled in the accepting cycle
//                big_endian in   - 1 = MSB first, 0 = LSB first
//                data_out   out  - serial line, idles high
//                busy       out  - high while a frame is in progress
//                done       out  - one-cycle pulse in first IDLE cycle after
//                                  a completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_ordered
    import serial_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int FRAMED  = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data_in,
    input  logic              big_endian,
    output logic              data_out,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("serial_tx_ordered: DATA_W must lie in 2..32");
    end
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("serial_tx_ordered: CLK_DIV must lie in 2..65535");
    end

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    tx_state_t         state,    state_nx;
    logic [DATA_W-1:0] shreg,    shreg_nx;
    logic [DIV_W-1:0]  div_cnt,  div_nx;
    logic [BIT_W-1:0]  bit_cnt,  bit_nx;
    logic              dout_nx;
    logic              busy_nx;
    logic              done_nx;

    logic [DATA_W-1:0] ordered;

    // Big-endian frames are mirrored at load time so that the datapath only
    // ever shifts out LSB-first.
    bit_order #(
        .DATA_W (DATA_W)
    ) u_bit_order (
        .data    (data_in),
        .reverse (big_endian),
        .out     (ordered)
    );

    // ------------------------------------------------------------------
    // State register. The serial outputs are registered here as well so
    // that nothing reaches a port combinationally from an input.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            data_out <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            div_cnt  <= div_nx;
            bit_cnt  <= bit_nx;
            data_out <= dout_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // The value computed for data_out is the bit that will be on the line
    // during the *next* cycle, so each transition loads the bit that the
    // new state presents. bit_cnt counts payload bits still to follow the
    // one currently on the line.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        dout_nx  = data_out;
        busy_nx  = busy;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                dout_nx = 1'b1;
                if (trigger) begin
                    busy_nx = 1'b1;
                    div_nx  = DIV_LAST;
                    if (FRAMED != 0) begin
                        state_nx = START;
                        shreg_nx = ordered;
                        dout_nx  = 1'b0;
                    end else begin
                        // No start bit: the first payload bit goes out
                        // straight away.
                        state_nx = DATA;
                        shreg_nx = ordered >> 1;
                        dout_nx  = ordered[0];
                        bit_nx   = BIT_LAST;
                    end
                end
            end

            START: begin
                if (div_cnt == '0) begin
                    state_nx = DATA;
                    div_nx   = DIV_LAST;
                    dout_nx  = shreg[0];
                    shreg_nx = shreg >> 1;
                    bit_nx   = BIT_LAST;
                end else begin
                    div_nx = div_cnt - 1'b1;
                end
            end

            DATA: begin
                if (div_cnt == '0) begin
                    div_nx = DIV_LAST;
                    if (bit_cnt == '0) begin
                        dout_nx = 1'b1;
                        if (FRAMED != 0) begin
                            state_nx = STOP;
                        end else begin
                            state_nx = IDLE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        dout_nx  = shreg[0];
                        shreg_nx = shreg >> 1;
                        bit_nx   = bit_cnt - 1'b1;
                    end
                end else begin
                    div_nx = div_cnt - 1'b1;
                end
            end

            STOP: begin
                if (div_cnt == '0) begin
                    state_nx = IDLE;
                    dout_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    div_nx = div_cnt - 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                dout_nx  = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_ordered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_ordered
//  Description : Scoreboard bench for serial_tx_ordered. Instance A is the
//                framed 8-bit build, instance B the unframed 12-bit build,
//                both with a 4-cycle bit period. Drivers predict acceptance
//                from a frame-timing model and queue the expected frame;
//                per-instance monitors compare the serial line against the
//                queued frame and check the done timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_ordered;

    localparam int DIV   = 4;
    localparam int W_A   = 8;
    localparam int W_B   = 12;
    localparam int LEN_A = DIV * (W_A + 2);
    localparam int LEN_B = DIV * W_B;

    typedef struct {
        logic [31:0] d;
        logic        be;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic           trig_a, be_a, dout_a, busy_a, done_a;
    logic [W_A-1:0] din_a;
    logic           trig_b, be_b, dout_b, busy_b, done_b;
    logic [W_B-1:0] din_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   free_a = 0, free_b = 0;
    int   last_acc_a = 0;
    int   idx_a = 0, errs_a = 0;
    int   idx_b = 0, errs_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx_ordered #(.DATA_W(W_A), .CLK_DIV(DIV), .FRAMED(1)) dut_a (
        .clk_in(clk), .rst_in(rst), .trigger(trig_a), .data_in(din_a),
        .big_endian(be_a), .data_out(dout_a), .busy(busy_a), .done(done_a)
    );

    serial_tx_ordered #(.DATA_W(W_B), .CLK_DIV(DIV), .FRAMED(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .trigger(trig_b), .data_in(din_b),
        .big_endian(be_b), .data_out(dout_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line level expected during the i-th busy cycle of a frame, derived
    // directly from the frame format: optional start bit, payload in the
    // requested order, optional stop bit, each lasting DIV cycles.
    function automatic logic exp_bit(input int framed, input int w,
                                     input logic [31:0] d, input logic be,
                                     input int i);
        int b;
        b = i / DIV;
        if (framed != 0) begin
            if (b == 0)     return 1'b0;
            if (b == w + 1) return 1'b1;
            b = b - 1;
        end
        if (b >= w) return 1'bx;
        return be ? d[w-1-b] : d[b];
    endfunction

    // Drivers: called at a falling edge; trigger is sampled on the next
    // rising edge. The model accepts only when its previous frame is over.
    task automatic send_a(input logic [W_A-1:0] d, input logic be);
        exp_t e;
        trig_a = 1'b1; din_a = d; be_a = be;
        if (cyc >= free_a) begin
            e.d = 32'(d); e.be = be; e.done_cyc = cyc + 1 + LEN_A;
            exp_a.push_back(e);
            last_acc_a = cyc + 1;
            free_a     = cyc + 1 + LEN_A;
        end
        @(negedge clk);
        trig_a = 1'b0; din_a = W_A'($urandom); be_a = 1'($urandom);
    endtask

    task automatic send_b(input logic [W_B-1:0] d, input logic be);
        exp_t e;
        trig_b = 1'b1; din_b = d; be_b = be;
        if (cyc >= free_b) begin
            e.d = 32'(d); e.be = be; e.done_cyc = cyc + 1 + LEN_B;
            exp_b.push_back(e);
            free_b = cyc + 1 + LEN_B;
        end
        @(negedge clk);
        trig_b = 1'b0; din_b = W_B'($urandom); be_b = 1'($urandom);
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            idx_a = 0; errs_a = 0;
        end else begin
            if (busy_a) begin
                if (exp_a.size() == 0) chk("a_busy_unrequested", int'(busy_a), 0);
                else begin
                    if (dout_a !== exp_bit(1, W_A, exp_a[0].d, exp_a[0].be, idx_a)) errs_a++;
                    idx_a++;
                end
            end else begin
                chk("a_idle_line", int'(dout_a), 1);
            end
            if (done_a) begin
                if (exp_a.size() == 0) chk("a_unexpected_done", int'(done_a), 0);
                else begin
                    e = exp_a.pop_front();
                    chk("a_done_cycle", cyc, e.done_cyc);
                    chk("a_frame_len", idx_a, LEN_A);
                    chk("a_bit_errors", errs_a, 0);
                end
                idx_a = 0; errs_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            idx_b = 0; errs_b = 0;
        end else begin
            if (busy_b) begin
                if (exp_b.size() == 0) chk("b_busy_unrequested", int'(busy_b), 0);
                else begin
                    if (dout_b !== exp_bit(0, W_B, exp_b[0].d, exp_b[0].be, idx_b)) errs_b++;
                    idx_b++;
                end
            end else begin
                chk("b_idle_line", int'(dout_b), 1);
            end
            if (done_b) begin
                if (exp_b.size() == 0) chk("b_unexpected_done", int'(done_b), 0);
                else begin
                    e = exp_b.pop_front();
                    chk("b_done_cycle", cyc, e.done_cyc);
                    chk("b_frame_len", idx_b, LEN_B);
                    chk("b_bit_errors", errs_b, 0);
                end
                idx_b = 0; errs_b = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int drain;
        rst = 1'b1;
        trig_a = 1'b0; din_a = '0; be_a = 1'b0;
        trig_b = 1'b0; din_b = '0; be_b = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_dout_a", int'(dout_a), 1);
        chk("reset_busy_a", int'(busy_a), 0);
        chk("reset_done_a", int'(done_a), 0);
        chk("reset_dout_b", int'(dout_b), 1);
        chk("reset_busy_b", int'(busy_b), 0);

        // Trigger in the very first cycle after reset release.
        rst = 1'b0;
        send_a(8'hA5, 1'b0);
        while (cyc < free_a) @(negedge clk);

        // MSB-first frame; input changes after acceptance must not matter.
        send_a(8'h01, 1'b1);
        din_a = 8'hFF; be_a = 1'b0;
        while (cyc < last_acc_a + 9) @(negedge clk);
        send_a(8'h3C, 1'b0);                 // mid-frame: ignored
        while (cyc < free_a) @(negedge clk);
        send_a(W_A'($urandom), 1'($urandom)); // lands on the done cycle
        chk("b2b_busy_next_cycle", int'(busy_a), 1);
        chk("b2b_start_bit", int'(dout_a), 0);
        while (cyc < free_a) @(negedge clk);

        // Reset at frame cycle 17: frame is abandoned with no done pulse.
        send_a(8'hC3, 1'b0);
        while (cyc < last_acc_a + 16) @(negedge clk);
        chk("pre_reset_busy", int'(busy_a), 1);
        rst = 1'b1;
        #1;
        chk("midreset_dout", int'(dout_a), 1);
        chk("midreset_busy", int'(busy_a), 0);
        chk("midreset_done", int'(done_a), 0);
        exp_a.delete();
        free_a = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        // Randomised traffic with random gaps; many triggers land mid-frame.
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send_a(W_A'($urandom), 1'($urandom));
        end

        // Unframed 12-bit instance.
        send_b(12'hF0F, 1'b0);
        while (cyc < free_b) @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_b(W_B'($urandom), 1'($urandom));
        end

        drain = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && drain < 500) begin
            @(negedge clk);
            drain++;
        end
        chk("pending_frames_a", exp_a.size(), 0);
        chk("pending_frames_b", exp_b.size(), 0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_ordered.md
SERIAL_TX_ORDERED -- requirements
Module: serial_tx_ordered

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, giving the payload bits per frame (legal range 2..32).
REQ-002 The block SHALL expose parameter CLK_DIV, default 868, giving clk_in cycles per serial bit (legal range 2..65535; 868 gives 115200 baud at 100 MHz).
REQ-003 The block SHALL expose parameter FRAMED, default 1: 1 = start bit (0) + payload + stop bit (1); 0 = payload only.
REQ-004 clk_in  input  1  single system clock; all state on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 trigger  input  1  one-cycle request to send data_in.
REQ-007 data_in  input  DATA_W  payload to send.
REQ-008 big_endian  input  1  1 = send data_in[DATA_W-1] first; 0 = send data_in[0] first.
REQ-009 data_out  output  1  serial line, idles high.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; with FRAMED=0, START and STOP SHALL never be entered.
REQ-013 In IDLE, trigger=1 SHALL latch data_in into the shift register, bit-reversed when big_endian=1 and unchanged otherwise, and move to START (FRAMED=1) or DATA (FRAMED=0).
REQ-014 data_in and big_endian SHALL be sampled only in the accepting cycle; later changes SHALL NOT affect the frame in flight.
REQ-015 The first serial bit SHALL appear on data_out in the cycle after the accepting cycle.
REQ-016 Each serial bit SHALL be held exactly CLK_DIV cycles, timed by a down-counter reloaded at every bit boundary.
REQ-017 DATA SHALL shift out the latched word LSB-first over exactly DATA_W bit periods, tracked by a bit counter of width $clog2(DATA_W+1).
REQ-018 After the last bit period (stop bit, or last payload bit when FRAMED=0) the FSM SHALL return to IDLE.
REQ-019 Frame length SHALL be CLK_DIV*(DATA_W+2) cycles when FRAMED=1 and CLK_DIV*DATA_W cycles when FRAMED=0.
REQ-020 busy SHALL be high in every non-IDLE cycle and low in IDLE.
REQ-021 done SHALL be high exactly in the first IDLE cycle following a frame and low otherwise.
REQ-022 trigger while busy SHALL be ignored, with no queuing.
REQ-023 trigger in the same cycle as done SHALL be accepted, so frames can run back-to-back with no idle gap beyond that cycle.
REQ-024 In IDLE, data_out SHALL be 1 and the counters SHALL hold.
REQ-025 Outputs data_out, busy and done SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-026 Assertion of rst_in, including mid-frame, SHALL immediately force IDLE, data_out=1, busy=0, done=0, and clear the counters and shift register.
REQ-027 The first cycle after rst_in deasserts SHALL accept a trigger.

Structure
REQ-028 Package serial_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and the default constants DEFAULT_DATA_W=8 and DEFAULT_CLK_DIV=868.
REQ-029 The bit reversal SHALL be a parametrised combinational sub-module bit_order (DATA_W, data, reverse, out), instantiated once.
REQ-030 Elaboration SHALL fail when DATA_W or CLK_DIV is outside its legal range.

Verification (bench parameters: CLK_DIV=4, DATA_W=8, FRAMED=1 unless stated)
REQ-031 data_in=8'hA5, big_endian=0, trigger -> data_out: 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles; busy for 40 cycles; one done pulse.
REQ-032 data_in=8'h01, big_endian=1 -> payload 0,0,0,0,0,0,0,1; data_in changed to 8'hFF one cycle after trigger -> frame unchanged.
REQ-033 trigger again at frame cycle 10 -> ignored; trigger in the done cycle -> second start bit begins the next cycle.
REQ-034 rst_in asserted at frame cycle 17 -> same cycle: data_out=1, busy=0, done=0; no done pulse follows.
REQ-035 FRAMED=0, DATA_W=12, data_in=12'hF0F, big_endian=0 -> 12 bits 1111_0000_1111 for 48 cycles, no start or stop bit, done pulse.
